// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants for the multi-channel clock divider.
// Revision 1.0
`default_nettype none

package clk_div_pkg;
  localparam int   CH_IDX_W     = 4;
  localparam int   MAX_N_CH     = 16;
  localparam logic CFG_SEL_HIGH = 1'b0;
  localparam logic CFG_SEL_LOW  = 1'b1;
endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadow/active half-period registers.
// Optional feature macro: CLK_DIV_DUTY_EN (separate low-phase register). Revision 1.0
`default_nettype none

module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int W            = 32,
  parameter int DEFAULT_HALF = 166
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         sync,
  input  logic         we_high,
`ifdef CLK_DIV_DUTY_EN
  input  logic         we_low,
`endif
  input  logic [W-1:0] data,
  output logic         clkout,
  output logic         tick
);

  localparam logic [W-1:0] RST_HALF = W'(DEFAULT_HALF);

  logic [W-1:0] shadow_h;
  logic [W-1:0] active_h;
  logic [W-1:0] count;
  logic [W-1:0] shadow_h_nxt;
  logic [W-1:0] active_h_nxt;
  logic [W-1:0] low_nxt;
  logic         reload;
  logic         load_active;

  // Loads see a config write landing on the same edge (write-first).
  assign shadow_h_nxt = we_high ? data : shadow_h;
  assign reload       = (count == '0);
  assign load_active  = reload || !en || sync;
  assign active_h_nxt = load_active ? shadow_h_nxt : active_h;

`ifdef CLK_DIV_DUTY_EN
  logic [W-1:0] shadow_l;
  logic [W-1:0] active_l;
  logic [W-1:0] shadow_l_nxt;

  assign shadow_l_nxt = we_low ? data : shadow_l;
  assign low_nxt      = load_active ? shadow_l_nxt : active_l;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_l <= RST_HALF;
      active_l <= RST_HALF;
    end else begin
      shadow_l <= shadow_l_nxt;
      active_l <= low_nxt;
    end
  end
`else
  assign low_nxt = active_h_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_h <= RST_HALF;
      active_h <= RST_HALF;
      count    <= RST_HALF;
      clkout   <= 1'b0;
      tick     <= 1'b0;
    end else begin
      shadow_h <= shadow_h_nxt;
      active_h <= active_h_nxt;
      if (!en || sync) begin
        // Restart in the low phase so the first rise comes H+1 cycles later.
        count  <= shadow_h_nxt;
        clkout <= 1'b0;
        tick   <= 1'b0;
      end else if (reload) begin
        clkout <= !clkout;
        tick   <= !clkout;
        count  <= clkout ? low_nxt : active_h_nxt;
      end else begin
        count <= count - 1'b1;
        tick  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH independent programmable clock dividers with shared sync.
// Optional feature macro: CLK_DIV_DUTY_EN (per-channel low-phase register). Revision 1.0
`default_nettype none

module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int W            = 32,
  parameter int DEFAULT_HALF = 166
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     en,
  input  logic                sync,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic                cfg_sel,
  input  logic [W-1:0]        cfg_data,
  output logic [N_CH-1:0]     clkout,
  output logic [N_CH-1:0]     tick
);

  // Out-of-range channel indices match no generated channel and are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    logic we_high;

    assign hit     = cfg_we && (cfg_ch == CH_IDX_W'(i));
    assign we_high = hit && (cfg_sel == CFG_SEL_HIGH);

`ifdef CLK_DIV_DUTY_EN
    logic we_low;
    assign we_low = hit && (cfg_sel == CFG_SEL_LOW);
`endif

    clk_div_chan #(
      .W            (W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .sync    (sync),
      .we_high (we_high),
`ifdef CLK_DIV_DUTY_EN
      .we_low  (we_low),
`endif
      .data    (cfg_data),
      .clkout  (clkout[i]),
      .tick    (tick[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and random checks of clk_div_multi against a phase-length model.
// Honours CLK_DIV_DUTY_EN when defined. Revision 1.0
`default_nettype none

module tb_clk_div_multi;

  localparam int NC = 4;
  localparam int DH = 166;
`ifdef CLK_DIV_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] en;
  logic          sync;
  logic          cfg_we;
  logic [3:0]    cfg_ch;
  logic          cfg_sel;
  logic [31:0]   cfg_data;
  logic [NC-1:0] clkout;
  logic [NC-1:0] tick;

  int vectors = 0;
  int miscompares = 0;

  // Model state: programmed half-periods, cycles left in the current phase, output levels.
  int            sh_h[NC];
  int            sh_l[NC];
  int            remain[NC];
  logic [NC-1:0] m_out;
  logic [NC-1:0] m_tick;

  clk_div_multi #(.N_CH(NC), .W(32), .DEFAULT_HALF(DH)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .clkout   (clkout),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      sh_h[i]   = DH;
      sh_l[i]   = DH;
      remain[i] = DH + 1;
    end
    m_out  = '0;
    m_tick = '0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < NC; i++)
        if (cfg_we && cfg_ch == 4'(i)) begin
          if (!cfg_sel) sh_h[i] = int'(cfg_data);
          else if (DUTY) sh_l[i] = int'(cfg_data);
        end
      for (int i = 0; i < NC; i++) begin
        m_tick[i] = 1'b0;
        if (!en[i] || sync) begin
          m_out[i]  = 1'b0;
          remain[i] = sh_h[i] + 1;
        end else begin
          remain[i] = remain[i] - 1;
          if (remain[i] == 0) begin
            m_out[i]  = !m_out[i];
            m_tick[i] = m_out[i];
            remain[i] = (m_out[i] ? sh_h[i] : (DUTY ? sh_l[i] : sh_h[i])) + 1;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("clkout", 32'(clkout), 32'(m_out));
    check("tick", 32'(tick), 32'(m_tick));
  endtask

  task automatic cfg_write(input int ch, input logic sel, input int data);
    cfg_we   = 1'b1;
    cfg_ch   = 4'(ch);
    cfg_sel  = sel;
    cfg_data = 32'(data);
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    int rises[$];
    int hi;
    int toggles;
    int n_tick;
    logic prev;

    reset = 1'b1; en = '0; sync = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
    model_reset();
    #1;
    check("reset_clkout", 32'(clkout), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Default divider on channel 0: period 2*(166+1).
    en = 4'b0001;
    hi = 0;
    for (int k = 1; k <= 700; k++) begin
      step();
      if (tick[0]) rises.push_back(k);
      if (clkout[0]) hi++;
    end
    check("def_nrise", 32'(rises.size()), 32'd2);
    check("def_first", 32'(rises[0]), 32'd167);
    check("def_period", 32'(rises[1] - rises[0]), 32'd334);
    check("def_high", 32'(hi), 32'd334);

    // Mid-phase reprogram of channel 1: old phase finishes, then period 10.
    rises.delete();
    en = 4'b0011;
    for (int k = 1; k <= 200; k++) begin
      if (k == 51) cfg_write(1, 1'b0, 4);
      else step();
      if (tick[1]) rises.push_back(k);
    end
    check("ch1_first", 32'(rises[0]), 32'd167);
    check("ch1_period", 32'(rises[1] - rises[0]), 32'd10);

    // Half=0 on channel 2: toggles every cycle.
    cfg_write(2, 1'b0, 0);
    en = 4'b0111;
    toggles = 0; n_tick = 0; prev = clkout[2];
    for (int k = 1; k <= 20; k++) begin
      step();
      if (clkout[2] != prev) toggles++;
      if (tick[2]) n_tick++;
      prev = clkout[2];
    end
    check("ch2_toggles", 32'(toggles), 32'd20);
    check("ch2_ticks", 32'(n_tick), 32'd10);

    // Sync aligns channels 0 (half 2) and 1 (half 5).
    cfg_write(0, 1'b0, 2);
    cfg_write(1, 1'b0, 5);
    repeat (7) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_low", 32'(clkout[1:0]), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 2) check("sync_ch0_pre", 32'(clkout[0]), 32'd0);
      if (k == 3) check("sync_ch0_rise", 32'(clkout[0]), 32'd1);
      if (k == 5) check("sync_ch1_pre", 32'(clkout[1]), 32'd0);
      if (k == 6) check("sync_ch1_rise", 32'(clkout[1]), 32'd1);
    end

    // Out-of-range channel write and (default build) low-register write are dropped.
    cfg_write(9, 1'b0, 1);
    cfg_write(0, 1'b1, 1);
    repeat (40) step();

    // Asynchronous reset mid-phase, then restart from the default half-period.
    #3 reset = 1'b1;
    #1;
    check("async_clkout", 32'(clkout), 32'd0);
    check("async_tick", 32'(tick), 32'd0);
    model_reset();
    step();
    reset = 1'b0;
    rises.delete();
    for (int k = 1; k <= 170; k++) begin
      step();
      if (tick[0]) rises.push_back(k);
    end
    check("rst_first", 32'(rises[0]), 32'd167);

    // Randomized traffic.
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 49) == 0) en = 4'($urandom);
      sync     = ($urandom_range(0, 63) == 0);
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_ch   = 4'($urandom_range(0, 5));
      cfg_sel  = 1'($urandom);
      cfg_data = 32'($urandom_range(0, 7));
      reset    = ($urandom_range(0, 799) == 0);
      step();
    end
    reset = 1'b0; sync = 1'b0; cfg_we = 1'b0;

`ifdef CLK_DIV_DUTY_EN
    // Asymmetric duty: high 2 cycles, low 4 cycles.
    en = '0;
    step();
    cfg_write(0, 1'b0, 1);
    cfg_write(0, 1'b1, 3);
    en = 4'b0001;
    rises.delete();
    hi = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (tick[0]) rises.push_back(k);
      if (clkout[0]) hi++;
    end
    check("duty_first", 32'(rises[0]), 32'd2);
    check("duty_period", 32'(rises[1] - rises[0]), 32'd6);
    check("duty_high", 32'(hi), 32'd10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
